// File: rtl/tcm_dual_port_mem_pkg.sv
// Shared sizing constants and lane helpers for the tightly-coupled memory.
package tcm_dual_port_mem_pkg;

    localparam int TCM_ADDR_W = 17;
    localparam int TCM_WORDS  = 16384;
    localparam int TAG_W      = 11;
    localparam int WORD_IDX_W = 14;

    // Map a 4-lane store enable onto the lower or upper half of the 64-bit word.
    function automatic logic [7:0] lane_enables(input logic [3:0] wr, input logic upper);
        return upper ? {wr, 4'b0000} : {4'b0000, wr};
    endfunction

endpackage

// File: rtl/tcm_dual_port_mem_if.sv
// Core-facing fetch and load/store bus of the TCM; the core side is master.
interface tcm_dual_port_mem_if;
    import tcm_dual_port_mem_pkg::*;

    logic             mem_i_rd_i;
    logic             mem_i_flush_i;
    logic             mem_i_invalidate_i;
    logic [31:0]      mem_i_pc_i;
    logic             mem_i_accept_o;
    logic             mem_i_valid_o;
    logic             mem_i_error_o;
    logic [63:0]      mem_i_inst_o;

    logic [31:0]      mem_d_addr_i;
    logic [31:0]      mem_d_data_wr_i;
    logic             mem_d_rd_i;
    logic [3:0]       mem_d_wr_i;
    logic             mem_d_cacheable_i;
    logic [TAG_W-1:0] mem_d_req_tag_i;
    logic             mem_d_invalidate_i;
    logic             mem_d_writeback_i;
    logic             mem_d_flush_i;
    logic [31:0]      mem_d_data_rd_o;
    logic             mem_d_accept_o;
    logic             mem_d_ack_o;
    logic             mem_d_error_o;
    logic [TAG_W-1:0] mem_d_resp_tag_o;

    modport master (
        output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
        output mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
        input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
    );

    modport slave (
        input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
        input  mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
        output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
    );

endinterface

// File: rtl/tcm_dual_port_ram.sv
// 16K x 64 dual-port RAM: port A read-only (read-first), port B byte-enable write plus read.
// Read data is registered (1 cycle); no backpressure. Contents survive reset.
module tcm_dual_port_ram
    import tcm_dual_port_mem_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_rd_i,
    input  logic [WORD_IDX_W-1:0] a_addr_i,
    output logic [63:0]           a_data_o,
    input  logic                  b_rd_i,
    input  logic [WORD_IDX_W-1:0] b_addr_i,
    input  logic [7:0]            b_be_i,
    input  logic [63:0]           b_wdata_i,
    output logic [63:0]           b_data_o
);

    logic [63:0] mem [TCM_WORDS];

    // Plain always: the backdoor task also deposits into this array.
    always @(posedge clk_i) begin
        for (int i = 0; i < 8; i++) begin
            if (b_be_i[i]) mem[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
        end
    end

    // Reads sample pre-edge contents, so a same-cycle store is not seen (read-first).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_data_o <= '0;
            b_data_o <= '0;
        end else begin
            if (a_rd_i) a_data_o <= mem[a_addr_i];
            if (b_rd_i) b_data_o <= mem[b_addr_i];
        end
    end

    task automatic write(input logic [TCM_ADDR_W-1:0] addr, input logic [7:0] data);
        mem[addr[TCM_ADDR_W-1:3]][addr[2:0]*8 +: 8] <= data;
    endtask

endmodule

// File: rtl/tcm_dual_port_mem.sv
// TCM top: 64-bit fetch port and 32-bit load/store port over a shared dual-port RAM.
// Fixed 1-cycle latency on both ports; accept is constant 1, so there is no backpressure.
module tcm_dual_port_mem
    import tcm_dual_port_mem_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    tcm_dual_port_mem_if.slave  bus
);

    logic [63:0] ram_a_data;
    logic [63:0] ram_b_data;
    logic        d_req;
    logic        upper_q;
    logic        valid_q;
    logic        ack_q;
    logic [TAG_W-1:0] tag_q;

    assign d_req = bus.mem_d_rd_i | (|bus.mem_d_wr_i) | bus.mem_d_flush_i |
                   bus.mem_d_invalidate_i | bus.mem_d_writeback_i;

    tcm_dual_port_ram u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_rd_i    (bus.mem_i_rd_i),
        .a_addr_i  (bus.mem_i_pc_i[TCM_ADDR_W-1:3]),
        .a_data_o  (ram_a_data),
        .b_rd_i    (bus.mem_d_rd_i),
        .b_addr_i  (bus.mem_d_addr_i[TCM_ADDR_W-1:3]),
        .b_be_i    (lane_enables(bus.mem_d_wr_i, bus.mem_d_addr_i[2])),
        .b_wdata_i ({bus.mem_d_data_wr_i, bus.mem_d_data_wr_i}),
        .b_data_o  (ram_b_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            tag_q   <= '0;
            upper_q <= 1'b0;
        end else begin
            valid_q <= bus.mem_i_rd_i;
            ack_q   <= d_req;
            if (d_req)          tag_q   <= bus.mem_d_req_tag_i;
            if (bus.mem_d_rd_i) upper_q <= bus.mem_d_addr_i[2];
        end
    end

    assign bus.mem_i_accept_o   = 1'b1;
    assign bus.mem_i_valid_o    = valid_q;
    assign bus.mem_i_error_o    = 1'b0;
    assign bus.mem_i_inst_o     = ram_a_data;
    assign bus.mem_d_accept_o   = 1'b1;
    assign bus.mem_d_ack_o      = ack_q;
    assign bus.mem_d_error_o    = 1'b0;
    assign bus.mem_d_resp_tag_o = tag_q;
    assign bus.mem_d_data_rd_o  = upper_q ? ram_b_data[63:32] : ram_b_data[31:0];

    // Aliased upper address bits, pc byte offset and maintenance hints carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{bus.mem_i_pc_i[31:TCM_ADDR_W], bus.mem_i_pc_i[2:0],
                             bus.mem_d_addr_i[31:TCM_ADDR_W], bus.mem_d_addr_i[1:0],
                             bus.mem_i_flush_i, bus.mem_i_invalidate_i, bus.mem_d_cacheable_i};

    task automatic write(input logic [31:0] addr, input logic [7:0] data);
        u_ram.write(addr[TCM_ADDR_W-1:0], data);
    endtask

endmodule

// File: tb/tb_tcm_dual_port_mem.sv
// Directed scoreboard bench for tcm_dual_port_mem: stimulus pushes expectations, a negedge monitor pops them.
module tb_tcm_dual_port_mem;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    tcm_dual_port_mem_if bus();
    tcm_dual_port_mem dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] iq [$];
    logic [43:0] dq [$];   // {check_data, tag, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.mem_i_rd_i = 0; bus.mem_i_flush_i = 0; bus.mem_i_invalidate_i = 0; bus.mem_i_pc_i = '0;
        bus.mem_d_addr_i = '0; bus.mem_d_data_wr_i = '0; bus.mem_d_rd_i = 0; bus.mem_d_wr_i = '0;
        bus.mem_d_cacheable_i = 0; bus.mem_d_req_tag_i = '0; bus.mem_d_invalidate_i = 0;
        bus.mem_d_writeback_i = 0; bus.mem_d_flush_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i); #1;
        idle();
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [63:0] exp);
        bus.mem_i_rd_i = 1; bus.mem_i_pc_i = pc;
        iq.push_back(exp);
    endtask

    task automatic dreq(input logic [31:0] addr, input logic [31:0] wdat, input logic [3:0] wr,
                        input logic rd, input logic [10:0] tag, input logic [31:0] exp);
        bus.mem_d_addr_i = addr; bus.mem_d_data_wr_i = wdat; bus.mem_d_wr_i = wr;
        bus.mem_d_rd_i = rd; bus.mem_d_req_tag_i = tag;
        dq.push_back({rd, tag, exp});
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_valid"}, 64'(bus.mem_i_valid_o), 64'd0);
        check({tag, "_ack"},   64'(bus.mem_d_ack_o), 64'd0);
        check({tag, "_rtag"},  64'(bus.mem_d_resp_tag_o), 64'd0);
        check({tag, "_inst"},  bus.mem_i_inst_o, 64'd0);
        check({tag, "_rdata"}, 64'(bus.mem_d_data_rd_o), 64'd0);
        check({tag, "_const"}, 64'({bus.mem_i_accept_o, bus.mem_d_accept_o,
                                     bus.mem_i_error_o, bus.mem_d_error_o}), 64'b1100);
    endtask

    // Monitor: every presented response must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (bus.mem_i_valid_o) begin
            if (iq.size() == 0) check("fetch_unexpected", 64'd1, 64'd0);
            else begin
                logic [63:0] e;
                e = iq.pop_front();
                check("fetch_inst", bus.mem_i_inst_o, e);
                check("fetch_err", 64'(bus.mem_i_error_o), 64'd0);
            end
        end
        if (bus.mem_d_ack_o) begin
            if (dq.size() == 0) check("ack_unexpected", 64'd1, 64'd0);
            else begin
                logic [43:0] e;
                e = dq.pop_front();
                check("resp_tag", 64'(bus.mem_d_resp_tag_o), 64'(e[42:32]));
                check("resp_err", 64'(bus.mem_d_error_o), 64'd0);
                if (e[43]) check("load_data", 64'(bus.mem_d_data_rd_o), 64'(e[31:0]));
            end
        end
    end

    localparam logic [63:0] INST0 = 64'h0010_0093_0000_0013;

    initial begin
        logic [7:0] img [16];
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
        idle();
        repeat (2) @(negedge clk_i);
        reset_values("in_reset");

        for (int i = 0; i < 8; i++) dut.write(32'h0000_0000 + i, img[i]);
        for (int i = 0; i < 8; i++) dut.write(32'h8000_0100 + i, img[8 + i]);

        @(posedge clk_i); #1;
        rst_i = 0;

        fetch(32'h8000_0000, INST0);                                  step();
        dreq(32'h8000_0104, 32'hDEAD_BEEF, 4'hF, 0, 11'h155, '0);     step();
        dreq(32'h8000_0104, '0, 4'h0, 1, 11'h001, 32'hDEAD_BEEF);     step();
        dreq(32'h8000_0100, '0, 4'h0, 1, 11'h002, 32'h1122_3344);     step();
        dreq(32'h8000_0100, 32'h0000_AA00, 4'h2, 0, 11'h003, '0);     step();
        dreq(32'h8000_0100, '0, 4'h0, 1, 11'h004, 32'h1122_AA44);     step();
        dreq(32'h0, '0, 4'h0, 0, 11'h007, '0); bus.mem_d_flush_i = 1;      step();
        dreq(32'h0, '0, 4'h0, 0, 11'h008, '0); bus.mem_d_invalidate_i = 1; step();
        dreq(32'h0, '0, 4'h0, 0, 11'h009, '0); bus.mem_d_writeback_i = 1;  step();

        // Store and fetch hit word 0x20 in the same cycle: fetch sees the old word.
        fetch(32'h0000_0100, 64'hDEAD_BEEF_1122_AA44);
        dreq(32'h0000_0100, 32'hCAFE_F00D, 4'hF, 0, 11'h00A, '0);     step();
        fetch(32'h0000_0104, 64'hDEAD_BEEF_CAFE_F00D);                step();

        fetch(32'h0, INST0); dreq(32'h0000_0100, '0, 4'h0, 1, 11'h010, 32'hCAFE_F00D); step();
        fetch(32'h0, INST0); dreq(32'h0000_0104, '0, 4'h0, 1, 11'h011, 32'hDEAD_BEEF); step();
        fetch(32'h0, INST0); dreq(32'h8000_0004, '0, 4'h0, 1, 11'h012, 32'h0010_0093); step();
        repeat (2) step();
        check("drain_fetch", 64'(iq.size()), 64'd0);
        check("drain_data",  64'(dq.size()), 64'd0);

        // Outstanding load and fetch killed by reset: neither may respond.
        bus.mem_d_rd_i = 1; bus.mem_d_addr_i = 32'h100; bus.mem_d_req_tag_i = 11'h3FF;
        bus.mem_i_rd_i = 1; bus.mem_i_pc_i = 32'h0;
        @(negedge clk_i); rst_i = 1;
        @(posedge clk_i); #1; idle();
        @(negedge clk_i);
        reset_values("reset_kill");
        @(posedge clk_i); #1; rst_i = 0;
        @(negedge clk_i);
        reset_values("post_reset");

        @(posedge clk_i); #1;
        fetch(32'h0, INST0); dreq(32'h0000_0100, '0, 4'h0, 1, 11'h020, 32'hCAFE_F00D); step();
        repeat (2) step();
        check("final_fetch_q", 64'(iq.size()), 64'd0);
        check("final_data_q",  64'(dq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
